// File: rtl/fir_regfile_sequencer.sv
// 4-tap FIR controller that uses an external 4x8 register file as a circular delay line.
// Clears the file after reset, then writes one sample, runs a two-cycle MAC and hands off the result.
module fir_regfile_sequencer #(
    parameter logic [7:0] C0 = 8'd1,
    parameter logic [7:0] C1 = 8'd2,
    parameter logic [7:0] C2 = 8'd3,
    parameter logic [7:0] C3 = 8'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [17:0] out_data,
    input  logic        out_ready,
    output logic        regWrite,
    output logic [1:0]  writeRegister,
    output logic [7:0]  writeData,
    output logic [1:0]  readRegister1,
    output logic [1:0]  readRegister2,
    input  logic [7:0]  readData1,
    input  logic [7:0]  readData2
);

    // Valid/ready: a transfer happens on a rising edge where both are 1; a raised valid
    // and its data stay stable until that edge, and ready never depends on valid.
    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_WRITE = 3'd2,
        S_MAC0  = 3'd3,
        S_MAC1  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  clr_cnt_q, clr_cnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  sample_q, sample_d;
    logic [17:0] acc_q, acc_d;

    logic [7:0]  coef_1, coef_2;
    logic [15:0] prod_1, prod_2;
    logic [17:0] mac_sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= 2'd0;
            ptr_q     <= 2'd0;
            sample_q  <= 8'd0;
            acc_q     <= 18'd0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ptr_q     <= ptr_d;
            sample_q  <= sample_d;
            acc_q     <= acc_d;
        end
    end

    // Both read ports are multiplied in each MAC cycle; only the coefficient pair changes.
    always_comb begin
        coef_1  = (state_q == S_MAC1) ? C2 : C0;
        coef_2  = (state_q == S_MAC1) ? C3 : C1;
        prod_1  = 16'(readData1) * 16'(coef_1);
        prod_2  = 16'(readData2) * 16'(coef_2);
        mac_sum = 18'(prod_1) + 18'(prod_2);
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ptr_d     = ptr_q;
        sample_d  = sample_q;
        acc_d     = acc_q;
        case (state_q)
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 2'd1;
                if (clr_cnt_q == 2'd3) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (in_valid) begin
                    sample_d = in_data;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                acc_d   = 18'd0;
                state_d = S_MAC0;
            end
            S_MAC0: begin
                acc_d   = mac_sum;
                state_d = S_MAC1;
            end
            S_MAC1: begin
                acc_d   = acc_q + mac_sum;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    ptr_d   = ptr_q + 2'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Write enable is held off while reset is asserted so the file is not touched during reset.
    always_comb begin
        in_ready      = (state_q == S_IDLE);
        out_valid     = (state_q == S_DONE);
        out_data      = (state_q == S_DONE) ? acc_q : 18'd0;
        regWrite      = rst && ((state_q == S_CLEAR) || (state_q == S_WRITE));
        writeRegister = (state_q == S_CLEAR) ? clr_cnt_q : ptr_q;
        writeData     = (state_q == S_WRITE) ? sample_q : 8'd0;
        readRegister1 = 2'd0;
        readRegister2 = 2'd0;
        case (state_q)
            S_MAC0: begin
                readRegister1 = ptr_q;
                readRegister2 = ptr_q - 2'd1;
            end
            S_MAC1: begin
                readRegister1 = ptr_q - 2'd2;
                readRegister2 = ptr_q - 2'd3;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fir_regfile_sequencer.sv
// Bench for fir_regfile_sequencer: two instances (default and all-255 coefficients) share
// stimulus, each backed by a behavioural register file and checked against a delay-line model.
module tb_fir_regfile_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, regWrite_a;
    logic [17:0] out_data_a;
    logic [1:0]  writeRegister_a, rr1_a, rr2_a;
    logic [7:0]  writeData_a, rd1_a, rd2_a;

    logic        in_ready_b, out_valid_b, regWrite_b;
    logic [17:0] out_data_b;
    logic [1:0]  writeRegister_b, rr1_b, rr2_b;
    logic [7:0]  writeData_b, rd1_b, rd2_b;

    fir_regfile_sequencer dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
        .regWrite(regWrite_a), .writeRegister(writeRegister_a), .writeData(writeData_a),
        .readRegister1(rr1_a), .readRegister2(rr2_a),
        .readData1(rd1_a), .readData2(rd2_a)
    );

    fir_regfile_sequencer #(.C0(8'd255), .C1(8'd255), .C2(8'd255), .C3(8'd255)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
        .regWrite(regWrite_b), .writeRegister(writeRegister_b), .writeData(writeData_b),
        .readRegister1(rr1_b), .readRegister2(rr2_b),
        .readData1(rd1_b), .readData2(rd2_b)
    );

    // behavioural register files: synchronous write, combinational read, no reset
    logic [7:0] rf_a [4];
    logic [7:0] rf_b [4];
    always @(posedge clk) begin
        if (regWrite_a) rf_a[writeRegister_a] <= writeData_a;
        if (regWrite_b) rf_b[writeRegister_b] <= writeData_b;
    end
    assign rd1_a = rf_a[rr1_a];
    assign rd2_a = rf_a[rr2_a];
    assign rd1_b = rf_b[rr1_b];
    assign rd2_b = rf_b[rr2_b];

    // ---------------- scoreboard ----------------
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [17:0] exp_a_q [$];
    logic [17:0] exp_b_q [$];
    int          hist [4];
    logic [1:0]  model_wptr;
    logic [17:0] last_a, last_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (rst && out_valid_a && out_ready) begin
            if (exp_a_q.size() == 0) check("out_a_unexpected", 32'(exp_a_q.size()), 32'd1);
            else check("out_a", 32'(out_data_a), 32'(exp_a_q.pop_front()));
            if (exp_b_q.size() == 0) check("out_b_unexpected", 32'(exp_b_q.size()), 32'd1);
            else check("out_b", 32'(out_data_b), 32'(exp_b_q.pop_front()));
            last_a     = out_data_a;
            last_b     = out_data_b;
            model_wptr = model_wptr + 2'd1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic model_clear();
        exp_a_q.delete();
        exp_b_q.delete();
        for (int i = 0; i < 4; i++) hist[i] = 0;
        model_wptr = 2'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_data", 32'(out_data_a), 32'd0);
        check("rst_in_ready", 32'(in_ready_a), 32'd0);
        check("rst_regwrite", 32'(regWrite_a), 32'd0);
        check("rst_regwrite_b", 32'(regWrite_b), 32'd0);
    endtask

    task automatic release_and_check_clear();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("clr_regwrite", 32'(regWrite_a), 32'd1);
            check("clr_addr", 32'(writeRegister_a), 32'(i));
            check("clr_data", 32'(writeData_a), 32'd0);
            check("clr_in_ready", 32'(in_ready_a), 32'd0);
            check("clr_addr_b", 32'(writeRegister_b), 32'(i));
            @(negedge clk);
        end
        #1;
        check("idle_in_ready", 32'(in_ready_a), 32'd1);
        check("idle_regwrite", 32'(regWrite_a), 32'd0);
    endtask

    // call at a negedge (or just after); returns at the negedge after the input handshake
    task automatic send_sample(input logic [7:0] d);
        int n;
        int sa, sb;
        n = 0;
        while (!in_ready_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(in_ready_a), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        hist[3]  = hist[2];
        hist[2]  = hist[1];
        hist[1]  = hist[0];
        hist[0]  = int'(d);
        sa = hist[0] * 1 + hist[1] * 2 + hist[2] * 3 + hist[3] * 4;
        sb = (hist[0] + hist[1] + hist[2] + hist[3]) * 255;
        exp_a_q.push_back(18'(sa));
        exp_b_q.push_back(18'(sb));
        @(negedge clk);
        in_valid = 1'b0;
        check("wr_en", 32'(regWrite_a), 32'd1);
        check("wr_addr", 32'(writeRegister_a), 32'(model_wptr));
        check("wr_data", 32'(writeData_a), 32'(d));
        check("wr_in_ready", 32'(in_ready_a), 32'd0);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid_a && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("out_valid_wait", 32'(out_valid_a), 32'd1);
    endtask

    task automatic run_one(input logic [7:0] d);
        int cyc;
        send_sample(d);
        wait_out(cyc);
        check("latency", 32'(cyc), 32'd3);
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    int          imp_in  [5] = '{10, 0, 0, 0, 0};
    int          imp_exp [5] = '{10, 20, 30, 40, 0};
    int          stp_exp [5] = '{5, 15, 30, 50, 50};
    logic [17:0] held;
    int          cyc;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        last_a    = '0;
        last_b    = '0;
        model_clear();

        apply_reset();
        release_and_check_clear();

        for (int i = 0; i < 5; i++) begin
            run_one(8'(imp_in[i]));
            check("impulse", 32'(last_a), 32'(imp_exp[i]));
        end

        for (int i = 0; i < 5; i++) begin
            run_one(8'd5);
            check("step", 32'(last_a), 32'(stp_exp[i]));
        end

        for (int i = 0; i < 4; i++) run_one(8'd255);
        check("ovf_b", 32'(last_b), 32'd260100);
        check("ovf_a", 32'(last_a), 32'd2550);

        // backpressure: result held while consumer stalls
        out_ready = 1'b0;
        send_sample(8'd77);
        wait_out(cyc);
        held = out_data_a;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid_a), 32'd1);
            check("bp_data", 32'(out_data_a), 32'(held));
            check("bp_in_ready", 32'(in_ready_a), 32'd0);
            check("bp_ptr", 32'(writeRegister_a), 32'(model_wptr));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid_a), 32'd0);
        check("bp_release_idle", 32'(in_ready_a), 32'd1);

        // random samples with random stalls
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b0;
            send_sample(8'($urandom_range(0, 255)));
            wait_out(cyc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
        end

        // reset during MAC1 discards the in-flight result
        send_sample(8'd9);
        @(negedge clk);
        @(negedge clk);
        check("mac1_no_valid", 32'(out_valid_a), 32'd0);
        rst      = 1'b0;
        model_clear();
        @(negedge clk);
        check("midrst_valid", 32'(out_valid_a), 32'd0);
        check("midrst_in_ready", 32'(in_ready_a), 32'd0);
        check("midrst_regwrite", 32'(regWrite_a), 32'd0);
        release_and_check_clear();
        run_one(8'd7);
        check("after_rst", 32'(last_a), 32'd7);
        check("after_rst_b", 32'(last_b), 32'd1785);

        repeat (3) @(negedge clk);
        check("drain_a", 32'(exp_a_q.size()), 32'd0);
        check("drain_b", 32'(exp_b_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
